// File: rtl/interrupt_control_mc.sv
// Multi-channel interrupt controller: per-channel edge counting, pending/in-service FSM,
// sticky overflow, and a fixed-priority (lowest index first) summary for the dispatcher.
module interrupt_control_mc #(
   parameter int NUM_CH = 3,
   parameter int DEPTH  = 32,
   parameter int CNT_W  = $clog2(DEPTH + 1),
   parameter int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_CH-1:0]         interrupt_request,
   input  logic [NUM_CH-1:0]         interrupt_enable,
   input  logic [NUM_CH-1:0]         interrupt_handling,
   input  logic [NUM_CH-1:0]         RETI,
   input  logic [NUM_CH-1:0]         ovf_clear,
   output logic [NUM_CH-1:0]         interrupt_flag,
   output logic [NUM_CH-1:0]         in_service,
   output logic [NUM_CH*CNT_W-1:0]   pending_cnt,
   output logic [NUM_CH-1:0]         overflow,
   output logic                      irq_any,
   output logic [ID_W-1:0]           irq_id
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_SERV = 2'd2
   } ch_state_t;

   logic [NUM_CH-1:0] req_prev_reg;
   logic [NUM_CH-1:0] req_edge;

   // Tracks the raw request regardless of enable, so enabling onto a high level is not an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_prev_reg <= '0;
      end else begin
         req_prev_reg <= interrupt_request;
      end
   end

   assign req_edge = interrupt_request & ~req_prev_reg;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         ch_state_t        state_reg, state_next;
         logic [CNT_W-1:0] cnt_reg, cnt_next;
         logic             ovf_reg, ovf_next;
         logic             inc, dec, at_depth;

         assign inc      = req_edge[gi] & interrupt_enable[gi];
         assign dec      = RETI[gi] & (state_reg == ST_SERV) & interrupt_enable[gi];
         assign at_depth = (cnt_reg == CNT_W'(DEPTH));

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state_reg <= ST_IDLE;
               cnt_reg   <= '0;
               ovf_reg   <= 1'b0;
            end else begin
               state_reg <= state_next;
               cnt_reg   <= cnt_next;
               ovf_reg   <= ovf_next;
            end
         end

         always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            ovf_next   = ovf_reg;
            if (!interrupt_enable[gi]) begin
               state_next = ST_IDLE;
               cnt_next   = '0;
               ovf_next   = 1'b0;
            end else begin
               if (ovf_clear[gi]) begin
                  ovf_next = 1'b0;
               end
               // A fresh overflow is applied after the clear so it wins a same-cycle collision.
               if (inc && !dec) begin
                  if (at_depth) begin
                     ovf_next = 1'b1;
                  end else begin
                     cnt_next = cnt_reg + CNT_W'(1);
                  end
               end else if (dec && !inc) begin
                  cnt_next = cnt_reg - CNT_W'(1);
               end
               case (state_reg)
                  ST_IDLE: if (inc) state_next = ST_PEND;
                  ST_PEND: if (interrupt_handling[gi]) state_next = ST_SERV;
                  ST_SERV: if (dec) state_next = (cnt_next != '0) ? ST_PEND : ST_IDLE;
                  default: state_next = ST_IDLE;
               endcase
            end
         end

         assign interrupt_flag[gi]                = (state_reg == ST_PEND);
         assign in_service[gi]                    = (state_reg == ST_SERV);
         assign pending_cnt[gi*CNT_W +: CNT_W]    = cnt_reg;
         assign overflow[gi]                      = ovf_reg;
      end
   endgenerate

   // Scan from the top down so the lowest pending index is the last one written.
   always_comb begin
      irq_id = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (interrupt_flag[i]) begin
            irq_id = ID_W'(i);
         end
      end
   end

   assign irq_any = |interrupt_flag;

endmodule

// File: doc/interrupt_control_mc.md
Name: interrupt_control_mc

Overview:
- Parametrised, clocked successor of the three-channel interrupt controller. Sits between the interrupt units and the multi-processor manager.
- Each of NUM_CH channels counts rising edges on its request line, up to DEPTH outstanding requests.
- Each channel runs a pending/in-service state machine driven by interrupt_handling and RETI.
- Adds overflow reporting, a pending-count readout and a fixed-priority summary (lowest index wins) for a shared dispatcher.

Parameters:
- NUM_CH, 3, number of interrupt channels (1..32).
- DEPTH, 32, max outstanding requests per channel (>=1).
- CNT_W, $clog2(DEPTH+1), width of each pending counter (derived, not overridden).
- ID_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1), width of the channel id (derived).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- interrupt_request  input  NUM_CH  level request per channel, synchronous to clk.
- interrupt_enable  input  NUM_CH  per-channel enable from the configuration register.
- interrupt_handling  input  NUM_CH  one-cycle pulse: the processor has entered the ISR of channel i.
- RETI  input  NUM_CH  one-cycle pulse: the processor has returned from the ISR of channel i.
- ovf_clear  input  NUM_CH  one-cycle pulse: clears the overflow bit of channel i.
- interrupt_flag  output  NUM_CH  channel i is pending and awaiting service.
- in_service  output  NUM_CH  channel i is currently being serviced.
- pending_cnt  output  NUM_CH*CNT_W  flattened outstanding counts, channel i at [i*CNT_W +: CNT_W].
- overflow  output  NUM_CH  sticky: an edge was dropped at DEPTH.
- irq_any  output  1  OR of interrupt_flag.
- irq_id  output  ID_W  lowest index i with interrupt_flag[i]=1; 0 when irq_any=0.

Behaviour:
- Reset (async assert, sync release): all counters 0; all states IDLE; req_prev=0; overflow=0. All outputs 0.
- Edge detect: edge[i] = interrupt_request[i] & ~req_prev[i]. req_prev updates every cycle regardless of enable, so enabling a channel while its request is already high produces no edge.
- Counter rules per channel, evaluated each clock:
  - inc = edge & enable.
  - dec = RETI & state==SERV & enable.
  - inc&dec: count unchanged.
  - inc only, count<DEPTH: count+1.
  - inc only, count==DEPTH: count holds, overflow<=1.
  - dec only: count-1 (dec is only possible while count>=1).
- FSM per channel:
  - IDLE: inc -> PEND. All other inputs ignored.
  - PEND: interrupt_handling -> SERV. inc/overflow still accumulate. RETI ignored.
  - SERV: dec, resulting count>0 -> PEND. dec, resulting count==0 -> IDLE. interrupt_handling ignored. inc still accumulates.
- Outputs are registered/decoded from state, no extra latency:
  - interrupt_flag[i] = (state==PEND).
  - in_service[i] = (state==SERV).
  - Request rising before clk edge k: flag high immediately after edge k.
- Disable (interrupt_enable[i]=0): next edge forces count=0, state=IDLE, overflow=0. Outputs for that channel read 0 from then on. This takes precedence over all other events.
- ovf_clear[i]: overflow[i]<=0. A simultaneous new overflow event wins (bit stays 1).
- irq_id/irq_any: combinational fixed-priority encode of interrupt_flag, channel 0 highest.
- Channels are fully independent. Simultaneous events on different channels are all honoured in the same cycle.

Test Plan:
- Reset, then pulse interrupt_request[0] for 1 cycle, enable=3'b111 -> after edge: flag=3'b001, pending_cnt ch0=1, irq_any=1, irq_id=0.
- Ch1: 3 request pulses, then handling, then RETI x3 -> cnt 1,2,3; handling gives in_service[1]=1, flag[1]=0; RETI #1 gives cnt=2, flag[1]=1. Re-enter via handling; final RETI gives cnt=0, IDLE, all outputs 0.
- DEPTH=4, ch2: 5 pulses -> cnt=4, overflow[2]=1. ovf_clear pulse -> overflow[2]=0, cnt still 4.
- Ch0 in SERV with cnt=1: request edge and RETI in the same cycle -> cnt=1, state PEND, flag[0]=1.
- Ch0 and ch2 both pending -> irq_id=0. Service ch0 to IDLE -> irq_id=2.
- Ch1 pending with cnt=2, then drop interrupt_enable[1] -> next cycle cnt=0, flag=0, overflow=0. Re-enable with request held high -> no new pending. Assert rst_n=0 mid-SERV -> all outputs 0 immediately.
